// File: rtl/otter_pkg.sv
// Shared OTTER pipeline definitions: ALU operation codes and base opcodes.
package otter_pkg;

   // Encoded as {funct7[5], funct3}
   typedef enum logic [3:0] {
      ADD      = 4'b0000,
      SLL      = 4'b0001,
      SLT      = 4'b0010,
      SLTU     = 4'b0011,
      XOR      = 4'b0100,
      SRL      = 4'b0101,
      OR       = 4'b0110,
      AND      = 4'b0111,
      SUB      = 4'b1000,
      LUI_COPY = 4'b1001,
      SRA      = 4'b1101
   } alu_fun_t;

   typedef enum logic [6:0] {
      LUI    = 7'b0110111,
      AUIPC  = 7'b0010111,
      JAL    = 7'b1101111,
      JALR   = 7'b1100111,
      BRANCH = 7'b1100011,
      LOAD   = 7'b0000011,
      STORE  = 7'b0100011,
      OP_IMM = 7'b0010011,
      OP     = 7'b0110011,
      SYSTEM = 7'b1110011
   } opcode_t;

endpackage

// File: rtl/Mult2to1.sv
// 32-bit two-input multiplexer; Sel=0 picks In1.
module Mult2to1 (
   input  logic [31:0] In1,
   input  logic [31:0] In2,
   input  logic        Sel,
   output logic [31:0] Out
);

   always_comb begin
      Out = Sel ? In2 : In1;
   end

endmodule

// File: rtl/Mult4to1.sv
// 32-bit four-input multiplexer; Sel=n picks In(n+1).
module Mult4to1 (
   input  logic [31:0] In1,
   input  logic [31:0] In2,
   input  logic [31:0] In3,
   input  logic [31:0] In4,
   input  logic [1:0]  Sel,
   output logic [31:0] Out
);

   always_comb begin
      Out = In1;
      unique case (Sel)
         2'd0: Out = In1;
         2'd1: Out = In2;
         2'd2: Out = In3;
         2'd3: Out = In4;
      endcase
   end

endmodule

// File: rtl/OTTER_ALU.sv
// Combinational RV32I ALU; unassigned operation codes yield zero.
module OTTER_ALU
   import otter_pkg::*;
(
   input  logic [3:0]  alu_fun,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] result
);

   always_comb begin
      result = '0;
      case (alu_fun_t'(alu_fun))
         ADD:      result = A + B;
         SUB:      result = A - B;
         SLL:      result = A << B[4:0];
         SRL:      result = A >> B[4:0];
         SRA:      result = $unsigned($signed(A) >>> B[4:0]);
         SLT:      result = {31'b0, $signed(A) < $signed(B)};
         SLTU:     result = {31'b0, A < B};
         XOR:      result = A ^ B;
         OR:       result = A | B;
         AND:      result = A & B;
         LUI_COPY: result = A;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/otter_exec_unit.sv
// OTTER execute stage: operand muxes, ALU, branch compares and the stallable
// result register feeding the memory stage.
module otter_exec_unit (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        EN,
   input  logic [31:0] RS1,
   input  logic [31:0] RS2,
   input  logic [31:0] U_IMM,
   input  logic [31:0] I_IMM,
   input  logic [31:0] S_IMM,
   input  logic [31:0] PC,
   input  logic        OPA_SEL,
   input  logic [1:0]  OPB_SEL,
   input  logic [3:0]  ALU_FUN,
   output logic [31:0] ALU_RESULT,
   output logic        BR_EQ,
   output logic        BR_LT,
   output logic        BR_LTU,
   output logic [31:0] RESULT_Q
);

   logic [31:0] opa;
   logic [31:0] opb;
   logic [31:0] result_d;
   logic [31:0] result_q;

   Mult2to1 u_opa_mux (
      .In1 (RS1),
      .In2 (U_IMM),
      .Sel (OPA_SEL),
      .Out (opa)
   );

   Mult4to1 u_opb_mux (
      .In1 (RS2),
      .In2 (I_IMM),
      .In3 (S_IMM),
      .In4 (PC),
      .Sel (OPB_SEL),
      .Out (opb)
   );

   OTTER_ALU u_alu (
      .alu_fun (ALU_FUN),
      .A       (opa),
      .B       (opb),
      .result  (ALU_RESULT)
   );

   // Flags use the muxed operands so they are valid whatever ALU_FUN is
   always_comb begin
      BR_EQ  = (opa == opb);
      BR_LT  = ($signed(opa) < $signed(opb));
      BR_LTU = (opa < opb);
   end

   always_comb begin
      result_d = EN ? ALU_RESULT : result_q;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         result_q <= '0;
      end else begin
         result_q <= result_d;
      end
   end

   assign RESULT_Q = result_q;

endmodule

// File: tb/tb_otter_exec_unit.sv
// Scoreboard bench for otter_exec_unit: stimulus pushes model expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_otter_exec_unit;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        EN = 1'b0;
   logic [31:0] RS1 = '0, RS2 = '0, U_IMM = '0, I_IMM = '0, S_IMM = '0, PC = '0;
   logic        OPA_SEL = 1'b0;
   logic [1:0]  OPB_SEL = 2'd0;
   logic [3:0]  ALU_FUN = 4'd0;
   logic [31:0] ALU_RESULT;
   logic        BR_EQ, BR_LT, BR_LTU;
   logic [31:0] RESULT_Q;

   otter_exec_unit dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .EN         (EN),
      .RS1        (RS1),
      .RS2        (RS2),
      .U_IMM      (U_IMM),
      .I_IMM      (I_IMM),
      .S_IMM      (S_IMM),
      .PC         (PC),
      .OPA_SEL    (OPA_SEL),
      .OPB_SEL    (OPB_SEL),
      .ALU_FUN    (ALU_FUN),
      .ALU_RESULT (ALU_RESULT),
      .BR_EQ      (BR_EQ),
      .BR_LT      (BR_LT),
      .BR_LTU     (BR_LTU),
      .RESULT_Q   (RESULT_Q)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       name;
      logic [31:0] alu;
      logic        eq;
      logic        lt;
      logic        ltu;
      logic [31:0] rq;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: register contents and what the next edge will do
   logic [31:0] m_q = '0;
   logic        p_en = 1'b0;
   logic        p_rst = 1'b1;
   logic [31:0] p_alu = '0;

   localparam int ModeNone  = 0;
   localparam int ModePulse = 1;
   localparam int ModeHold  = 2;

   function automatic logic signed_lt(logic [31:0] a, logic [31:0] b);
      // Flipping the sign bit maps two's complement order onto unsigned order
      return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
   endfunction

   function automatic logic [31:0] ref_alu(logic [3:0] f, logic [31:0] a, logic [31:0] b);
      int unsigned sh;
      sh = int'(b[4:0]);
      case (f)
         4'b0000: return a + b;
         4'b1000: return a - b;
         4'b0001: return a << sh;
         4'b0101: return a >> sh;
         4'b1101: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
         4'b0010: return {31'b0, signed_lt(a, b)};
         4'b0011: return {31'b0, a < b};
         4'b0100: return a ^ b;
         4'b0110: return a | b;
         4'b0111: return a & b;
         4'b1001: return a;
         default: return 32'h0;
      endcase
   endfunction

   task automatic apply(input string nm, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] u, input logic [31:0] i, input logic [31:0] s,
                        input logic [31:0] pc, input logic asel, input logic [1:0] bsel,
                        input logic [3:0] fun, input logic en, input int mode);
      logic [31:0] a, b, r;
      exp_t e;
      @(posedge CLK);
      #1;
      if (p_rst) m_q = 32'h0;
      else if (p_en) m_q = p_alu;
      RS1 = rs1; RS2 = rs2; U_IMM = u; I_IMM = i; S_IMM = s; PC = pc;
      OPA_SEL = asel; OPB_SEL = bsel; ALU_FUN = fun; EN = en;
      RESET = (mode == ModeHold);
      if (mode == ModePulse) begin
         RESET = 1'b1;
         #1;
         RESET = 1'b0;
      end
      if (mode != ModeNone) m_q = 32'h0;
      a = asel ? u : rs1;
      case (bsel)
         2'd0: b = rs2;
         2'd1: b = i;
         2'd2: b = s;
         default: b = pc;
      endcase
      r = ref_alu(fun, a, b);
      e.name = nm; e.alu = r; e.eq = (a == b); e.lt = signed_lt(a, b); e.ltu = (a < b);
      e.rq = m_q;
      sb.push_back(e);
      p_en = en; p_rst = (mode == ModeHold); p_alu = r;
   endtask

   // Monitor: one expectation per cycle, sampled mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checks += 4;
            if (ALU_RESULT !== e.alu) begin
               errors++;
               $display("FAIL %s alu_result got %h want %h", e.name, ALU_RESULT, e.alu);
            end
            if ({BR_EQ, BR_LT, BR_LTU} !== {e.eq, e.lt, e.ltu}) begin
               errors++;
               $display("FAIL %s flags eq/lt/ltu got %b%b%b want %b%b%b", e.name,
                        BR_EQ, BR_LT, BR_LTU, e.eq, e.lt, e.ltu);
            end
            if (RESULT_Q !== e.rq) begin
               errors++;
               $display("FAIL %s result_q got %h want %h", e.name, RESULT_Q, e.rq);
            end
            if ($isunknown({ALU_RESULT, RESULT_Q, BR_EQ, BR_LT, BR_LTU})) begin
               errors++;
               $display("FAIL %s unknown output got %h/%h want known", e.name, ALU_RESULT,
                        RESULT_Q);
            end
         end
      end
   end

   initial begin
      logic [31:0] r1, r2;
      int          md;
      int          waits;
      apply("reset",    32'h0,         32'h0, 0, 0, 0, 0, 1'b0, 2'd0, 4'b0000, 1'b1, ModeHold);
      apply("add_wrap", 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 1'b0, 2'd0, 4'b0000, 1'b1, ModeNone);
      apply("sub_wrap", 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 1'b0, 2'd0, 4'b1000, 1'b1, ModeNone);
      apply("sra", 32'h8000_0000, 32'h0, 0, 32'h24, 0, 0, 1'b0, 2'd1, 4'b1101, 1'b1, ModeNone);
      apply("srl", 32'h8000_0000, 32'h0, 0, 32'h24, 0, 0, 1'b0, 2'd1, 4'b0101, 1'b1, ModeNone);
      apply("sll", 32'h8000_0000, 32'h0, 0, 32'h24, 0, 0, 1'b0, 2'd1, 4'b0001, 1'b1, ModeNone);
      apply("slt",  32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 1'b0, 2'd0, 4'b0010, 1'b1, ModeNone);
      apply("sltu", 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 1'b0, 2'd0, 4'b0011, 1'b1, ModeNone);
      apply("s_imm", 32'h10, 32'h0, 0, 0, 32'hFFFF_FFF0, 0, 1'b0, 2'd2, 4'b0000, 1'b1, ModeNone);
      apply("pc_add", 32'h4, 32'h0, 0, 0, 0, 32'h100, 1'b0, 2'd3, 4'b0000, 1'b1, ModeNone);
      apply("stall1", 32'h55, 32'h3, 0, 0, 0, 0, 1'b0, 2'd0, 4'b0110, 1'b0, ModeNone);
      apply("stall2", 32'h77, 32'h77, 0, 0, 0, 0, 1'b0, 2'd0, 4'b0100, 1'b0, ModeNone);
      apply("stall_rst", 32'h1, 32'h2, 0, 0, 0, 0, 1'b0, 2'd0, 4'b0000, 1'b0, ModePulse);
      apply("lui_copy", 32'h0, 32'h0, 32'h1234_5000, 0, 0, 0, 1'b1, 2'd0, 4'b1001, 1'b1,
            ModeNone);
      apply("rst_en", 32'h0, 32'h0, 32'h1234_5000, 0, 0, 0, 1'b1, 2'd0, 4'b1001, 1'b1,
            ModeHold);
      apply("unused", 32'hDEAD_BEEF, 32'h1, 0, 0, 0, 0, 1'b0, 2'd0, 4'b1111, 1'b1, ModeNone);
      apply("post_rst", 32'h9, 32'h8, 0, 0, 0, 0, 1'b0, 2'd0, 4'b0111, 1'b1, ModeNone);
      for (int n = 0; n < 300; n++) begin
         r1 = $urandom;
         r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
         md = ($urandom_range(0, 19) == 0) ? ModePulse :
              ($urandom_range(0, 19) == 0) ? ModeHold : ModeNone;
         apply("random", r1, r2, $urandom, $urandom, $urandom, $urandom,
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), md);
      end
      waits = 0;
      while (sb.size() != 0 && waits < 10) begin
         @(posedge CLK);
         waits++;
      end
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending got %0d want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/otter_exec_unit.md
# otter_exec_unit

Execute-stage datapath slice of the pipelined OTTER RV32I core. Selects ALU operand A (rs1 or U-immediate) and operand B (rs2, I-imm, S-imm or PC), performs the ALU operation, and produces branch-compare flags. It also holds a stallable result register that feeds the memory stage. The operand muxes and ALU are combinational; only the result register is clocked.

## Interface
- Parameters: none; datapath fixed at 32 bits.
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-high; clears the result register.
- EN  in  1  result-register load enable (deasserted on stall).
- RS1  in  32  register-file operand A.
- RS2  in  32  register-file operand B.
- U_IMM  in  32  U-type immediate, already shifted.
- I_IMM  in  32  sign-extended I-immediate.
- S_IMM  in  32  sign-extended S-immediate.
- PC  in  32  instruction PC.
- OPA_SEL  in  1  operand A select: 0=RS1, 1=U_IMM.
- OPB_SEL  in  2  operand B select: 0=RS2, 1=I_IMM, 2=S_IMM, 3=PC.
- ALU_FUN  in  4  operation code.
- ALU_RESULT  out  32  combinational ALU result.
- BR_EQ, BR_LT, BR_LTU  out  1 each  combinational compares of the selected operand A vs operand B.
- RESULT_Q  out  32  registered ALU result.

## Operation
- The operand muxes are pure combinational. Select value n picks the (n+1)th data input.
- ALU_FUN encoding is {funct7[5], funct3}:
  - 0000 ADD, 1000 SUB (A−B)
  - 0001 SLL, 0101 SRL, 1101 SRA; shift amount is B[4:0]
  - 0010 SLT (signed), 0011 SLTU; result is 0 or 1, zero-extended
  - 0100 XOR, 0110 OR, 0111 AND
  - 1001 LUI copy: result = A
  - every other code: result = 0
- ADD and SUB wrap modulo 2^32; there is no overflow or carry output.
- SRA replicates A[31].
- Branch flags:
  - BR_EQ = (A==B)
  - BR_LT = signed A<B
  - BR_LTU = unsigned A<B
- The flags are computed on the muxed operands and are valid for every ALU_FUN.

## Timing
- ALU_RESULT and the BR_* flags settle in the same cycle as the inputs; latency is zero.
- RESULT_Q takes ALU_RESULT on the rising CLK edge when EN=1 and holds its value when EN=0.
- RESULT_Q goes to 0x00000000 immediately when RESET is asserted, without waiting for CLK, and stays 0 while RESET is high.
- RESET high at a clock edge with EN=1: reset wins and RESULT_Q stays 0.
- After RESET deasserts, the first EN=1 edge loads a normal result.
- Reset asserted mid-stall discards the held value.
- There is no handshake; the upstream hazard logic drives EN.

## Structure
- Shared package otter_pkg holds:
  - an alu_fun_t enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI_COPY
  - the opcode_t enum, already used by the pipeline.
- Leaf modules instantiated by this block:
  - Mult2to1 (In1, In2, Sel, Out)
  - Mult4to1 (In1..In4, Sel, Out)
  - OTTER_ALU (alu_fun, A, B, result); this is the natural sub-module and is combinational with an always_comb case.
- The top level adds the compare logic and the result register.

## Test plan
- ADD/SUB wrap:
  - OPA_SEL=0, OPB_SEL=0, RS1=0xFFFFFFFF, RS2=1, ALU_FUN=0000 → ALU_RESULT=0x00000000.
  - Same operands with ALU_FUN=1000 → ALU_RESULT=0xFFFFFFFE.
- Shifts with RS1=0x80000000, OPB_SEL=1, I_IMM=0x24 (shift amount 4):
  - SRA → 0xF8000000
  - SRL → 0x08000000
  - SLL → 0x00000000
- Compares with RS1=0xFFFFFFFF, RS2=1:
  - SLT → 1, SLTU → 0
  - flags: BR_LT=1, BR_LTU=0, BR_EQ=0
- Mux coverage: OPB_SEL=3 with PC=0x100 and RS1=4 under ADD → 0x104. OPA_SEL=1 with U_IMM=0x12345000 under LUI copy → 0x12345000. An unused ALU_FUN such as 1111 → 0.
- Register:
  - EN=1 latches 0x104 at the edge.
  - EN=0 with changed inputs holds 0x104.
  - RESET pulsed between edges clears RESULT_Q to 0 without a clock edge.
  - RESET high together with EN=1 at an edge keeps RESULT_Q at 0.
